// File: rtl/serial_gated_tx_pkg.sv
// serial_link_pkg: state encoding and shared constants for the serial link transmitter and receiver
package serial_link_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } tx_state_t;

    localparam int SER_WIDTH_DEFAULT = 8;
    localparam int SER_GAP_MAX       = 15;

endpackage

// File: rtl/serial_gated_tx_if.sv
// serial_gated_tx_if: valid/ready word handshake between a parallel producer and the transmitter
interface serial_gated_tx_if
    import serial_link_pkg::*;
#(
    parameter int WIDTH = SER_WIDTH_DEFAULT
);
    logic [WIDTH-1:0] tx_data;
    logic             tx_valid;
    logic             tx_ready;

    modport master (output tx_data, tx_valid, input tx_ready);
    modport slave  (input tx_data, tx_valid, output tx_ready);
endinterface

// File: rtl/serial_gated_tx_shreg.sv
// serial_shreg: loadable shift register whose serial tap follows the configured bit order
module serial_shreg #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             sout
);
    logic [WIDTH-1:0] q;

    assign sout = LSB_FIRST ? q[0] : q[WIDTH-1];

    // load has priority; shifting moves the next bit onto the tap
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q <= '0;
        else if (load)
            q <= din;
        else if (shift)
            q <= LSB_FIRST ? (q >> 1) : (q << 1);
    end
endmodule

// File: rtl/serial_gated_tx.sv
// serial_gated_tx: parallel-to-serial transmitter with per-bit strobe and programmable inter-word gap
module serial_gated_tx
    import serial_link_pkg::*;
#(
    parameter int WIDTH     = SER_WIDTH_DEFAULT,
    parameter int GAP       = 1,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    serial_gated_tx_if.slave tx,
    output logic             ser_d,
    output logic             ser_en,
    output logic             ser_sof,
    output logic             busy
);
    localparam int             CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  LAST     = CW'(WIDTH);
    localparam logic [3:0]     GAP_LOAD = 4'(GAP > 0 ? GAP - 1 : 0);

    tx_state_t        state, state_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [3:0]       gcnt, gcnt_n;
    logic             d_n, en_n, sof_n, load, shift, sout, accept, first;
    logic [WIDTH-1:0] rest;

    assign tx.tx_ready = (state == IDLE) || (state == SHIFT && cnt == LAST && GAP == 0);
    assign accept      = tx.tx_valid && tx.tx_ready;
    assign first       = LSB_FIRST ? tx.tx_data[0] : tx.tx_data[WIDTH-1];
    assign rest        = LSB_FIRST ? (tx.tx_data >> 1) : (tx.tx_data << 1);

    serial_shreg #(.WIDTH(WIDTH), .LSB_FIRST(LSB_FIRST)) u_shreg (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .shift (shift),
        .din   (rest),
        .sout  (sout)
    );

    // next state, counters and the next serial bit; an accept overrides whatever the state would do
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        gcnt_n  = gcnt;
        d_n     = 1'b0;
        en_n    = 1'b0;
        sof_n   = 1'b0;
        load    = 1'b0;
        shift   = 1'b0;
        if (accept) begin
            d_n     = first;
            en_n    = 1'b1;
            sof_n   = 1'b1;
            load    = 1'b1;
            cnt_n   = CW'(1);
            state_n = SHIFT;
        end else begin
            unique case (state)
                SHIFT: begin
                    if (cnt != LAST) begin
                        d_n   = sout;
                        en_n  = 1'b1;
                        shift = 1'b1;
                        cnt_n = cnt + 1'b1;
                    end else begin
                        state_n = (GAP > 0) ? serial_link_pkg::GAP : IDLE;
                        gcnt_n  = GAP_LOAD;
                        cnt_n   = '0;
                    end
                end
                serial_link_pkg::GAP: begin
                    gcnt_n  = (gcnt == 4'd0) ? 4'd0 : gcnt - 1'b1;
                    state_n = (gcnt == 4'd0) ? IDLE : serial_link_pkg::GAP;
                end
                default: ;
            endcase
        end
    end

    // state, counters and registered serial outputs; reset drops the strobe without waiting for clk
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            gcnt    <= '0;
            ser_d   <= 1'b0;
            ser_en  <= 1'b0;
            ser_sof <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            gcnt    <= gcnt_n;
            ser_d   <= d_n;
            ser_en  <= en_n;
            ser_sof <= sof_n;
            busy    <= (state_n != IDLE);
        end
    end
endmodule
